// File: rtl/pdh_pkg.sv
// rtl/pdh_pkg.sv - shared lock-state encoding, DAC constants and saturation helper
package pdh_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SWEEP  = 3'd1,
    SETTLE = 3'd2,
    LOCKED = 3'd3,
    FAULT  = 3'd4
  } lock_state_t;

  localparam logic [13:0] DAC_MID = 14'd8191;
  localparam logic [13:0] DAC_MAX = 14'd16383;

  function automatic logic [13:0] sat_u14(input logic signed [15:0] v);
    if (v < 16'sd0) return 14'd0;
    if (v > 16'sd16383) return DAC_MAX;
    return v[13:0];
  endfunction
endpackage

// File: rtl/pid_lock_sequencer_sweep_gen.sv
// rtl/pid_lock_sequencer_sweep_gen.sv - tick divider and triangle ramp for the lock sweep
module sweep_gen #(
  parameter int DEC_W = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [13:0]      load_val,
  input  logic             run,
  input  logic [13:0]      sweep_min,
  input  logic [13:0]      sweep_max,
  input  logic [7:0]       sweep_step,
  input  logic [DEC_W-1:0] sweep_div,
  output logic [13:0]      ramp,
  output logic [13:0]      ramp_nxt
);
  logic             dir_up, dir_nxt, tick, up_hit, dn_hit;
  logic [DEC_W-1:0] div_cnt, div_cnt_nxt, div_eff;
  logic [7:0]       step_eff;

  // ramp_nxt is exposed so the parent can register dac_o on the same edge the ramp moves
  always_comb begin
    step_eff    = (sweep_step == 8'd0) ? 8'd1 : sweep_step;
    div_eff     = (sweep_div == '0) ? DEC_W'(1) : sweep_div;
    tick        = (div_cnt >= div_eff - 1'b1);
    up_hit      = ({1'b0, ramp} + {7'd0, step_eff}) >= {1'b0, sweep_max};
    dn_hit      = {1'b0, ramp} <= ({1'b0, sweep_min} + {7'd0, step_eff});
    ramp_nxt    = ramp;
    dir_nxt     = dir_up;
    div_cnt_nxt = div_cnt;
    if (load) begin
      ramp_nxt    = load_val;
      dir_nxt     = 1'b1;
      div_cnt_nxt = '0;
    end else if (run) begin
      div_cnt_nxt = tick ? '0 : div_cnt + 1'b1;
      if (tick) begin
        if (dir_up) begin
          if (up_hit) begin
            ramp_nxt = sweep_max;
            dir_nxt  = 1'b0;
          end else begin
            ramp_nxt = ramp + {6'd0, step_eff};
          end
        end else begin
          if (dn_hit) begin
            ramp_nxt = sweep_min;
            dir_nxt  = 1'b1;
          end else begin
            ramp_nxt = ramp - {6'd0, step_eff};
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ramp    <= '0;
      dir_up  <= 1'b1;
      div_cnt <= '0;
    end else begin
      ramp    <= ramp_nxt;
      dir_up  <= dir_nxt;
      div_cnt <= div_cnt_nxt;
    end
  end
endmodule

// File: rtl/pid_lock_sequencer.sv
// rtl/pid_lock_sequencer.sv - sweep, capture, settle and lock-monitor sequencer ahead of pid_core
module pid_lock_sequencer
  import pdh_pkg::*;
#(
  parameter int DEC_W   = 14,
  parameter int DWELL_W = 16,
  parameter int RETRY_W = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      arm_i,
  input  logic signed [15:0]        trans_i,
  input  logic signed [15:0]        thr_lock_i,
  input  logic signed [15:0]        thr_loss_i,
  input  logic [13:0]               sweep_min_i,
  input  logic [13:0]               sweep_max_i,
  input  logic [7:0]                sweep_step_i,
  input  logic [DEC_W-1:0]          sweep_div_i,
  input  logic [DWELL_W-1:0]        settle_i,
  input  logic [DWELL_W-1:0]        lost_i,
  input  logic [RETRY_W-1:0]        max_retry_i,
  input  logic [13:0]               pid_out_i,
  output logic                      pid_en_o,
  output logic [13:0]               dac_o,
  output logic [2:0]                state_o,
  output logic                      locked_o,
  output logic                      fault_o,
  output logic [RETRY_W-1:0]        retry_o
);
  lock_state_t        state;
  logic [13:0]        hold, ramp, ramp_nxt, base, pid_dac, load_val;
  logic [DWELL_W-1:0] settle_cnt, lost_cnt, lost_eff;
  logic [RETRY_W-1:0] retry_new;
  logic               lock_hit, low, settle_done, lost_done, loss_evt, loss_fault, sg_load, sg_run;

  always_comb begin
    lock_hit    = trans_i >= thr_lock_i;
    low         = trans_i < thr_loss_i;
    lost_eff    = (lost_i == '0) ? DWELL_W'(1) : lost_i;
    settle_done = ({1'b0, settle_cnt} + 1'b1) >= {1'b0, settle_i};
    lost_done   = ({1'b0, lost_cnt} + 1'b1) >= {1'b0, lost_eff};
    loss_evt    = arm_i && low && ((state == SETTLE) || (state == LOCKED && lost_done));
    retry_new   = (&retry_o) ? retry_o : retry_o + 1'b1;
    loss_fault  = retry_new > max_retry_i;
    sg_load     = arm_i && ((state == IDLE && sweep_min_i < sweep_max_i) || (loss_evt && !loss_fault));
    load_val    = (state == IDLE) ? sweep_min_i : hold;
    sg_run      = arm_i && (state == SWEEP) && !lock_hit;
    // on the capture edge the hold register is not yet loaded, so use the live ramp
    base        = (state == SWEEP) ? ramp : hold;
    pid_dac     = sat_u14($signed({2'b00, base}) + $signed({2'b00, pid_out_i}) - 16'sd8191);
  end

  sweep_gen #(.DEC_W(DEC_W)) u_sweep (
    .clk        (clk),
    .rst        (rst),
    .load       (sg_load),
    .load_val   (load_val),
    .run        (sg_run),
    .sweep_min  (sweep_min_i),
    .sweep_max  (sweep_max_i),
    .sweep_step (sweep_step_i),
    .sweep_div  (sweep_div_i),
    .ramp       (ramp),
    .ramp_nxt   (ramp_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pid_en_o   <= 1'b0;
      dac_o      <= DAC_MID;
      locked_o   <= 1'b0;
      fault_o    <= 1'b0;
      retry_o    <= '0;
      hold       <= '0;
      settle_cnt <= '0;
      lost_cnt   <= '0;
    end else if (!arm_i) begin
      state    <= IDLE;
      pid_en_o <= 1'b0;
      dac_o    <= DAC_MID;
      locked_o <= 1'b0;
      fault_o  <= 1'b0;
    end else if (loss_evt) begin
      retry_o  <= retry_new;
      pid_en_o <= 1'b0;
      locked_o <= 1'b0;
      if (loss_fault) begin
        state   <= FAULT;
        fault_o <= 1'b1;
        dac_o   <= DAC_MID;
      end else begin
        state <= SWEEP;
        dac_o <= ramp_nxt;
      end
    end else begin
      case (state)
        IDLE: begin
          retry_o <= '0;
          if (sweep_min_i >= sweep_max_i) begin
            state   <= FAULT;
            fault_o <= 1'b1;
          end else begin
            state <= SWEEP;
            dac_o <= ramp_nxt;
          end
        end
        SWEEP: begin
          if (lock_hit) begin
            state      <= SETTLE;
            hold       <= ramp;
            pid_en_o   <= 1'b1;
            settle_cnt <= '0;
            dac_o      <= pid_dac;
          end else begin
            dac_o <= ramp_nxt;
          end
        end
        SETTLE: begin
          dac_o <= pid_dac;
          if (settle_done) begin
            state    <= LOCKED;
            locked_o <= 1'b1;
            lost_cnt <= '0;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        LOCKED: begin
          dac_o    <= pid_dac;
          lost_cnt <= low ? lost_cnt + 1'b1 : '0;
        end
        default: begin
          state    <= FAULT;
          fault_o  <= 1'b1;
          pid_en_o <= 1'b0;
          dac_o    <= DAC_MID;
        end
      endcase
    end
  end

  assign state_o = state;
endmodule

// File: tb/tb_pid_lock_sequencer.sv
// tb/tb_pid_lock_sequencer.sv - directed bench with a cycle model of the lock sequencer
module tb_pid_lock_sequencer;
  localparam int DEC_W = 14, DWELL_W = 16, RETRY_W = 4;

  logic clk = 1'b0, rst = 1'b1, arm = 1'b0;
  logic signed [15:0] trans = 16'sd0, thr_lock = 16'sd1000, thr_loss = 16'sd500;
  logic [13:0] sweep_min = 14'd1000, sweep_max = 14'd1100, pid_out = 14'd8191;
  logic [7:0] sweep_step = 8'd10;
  logic [DEC_W-1:0] sweep_div = 14'd4;
  logic [DWELL_W-1:0] settle = 16'd100, lost = 16'd8;
  logic [RETRY_W-1:0] max_retry = 4'd2;
  logic pid_en, locked, fault;
  logic [13:0] dac;
  logic [2:0] state;
  logic [RETRY_W-1:0] retry;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  pid_lock_sequencer #(.DEC_W(DEC_W), .DWELL_W(DWELL_W), .RETRY_W(RETRY_W)) dut (
    .clk(clk), .rst(rst), .arm_i(arm), .trans_i(trans), .thr_lock_i(thr_lock),
    .thr_loss_i(thr_loss), .sweep_min_i(sweep_min), .sweep_max_i(sweep_max),
    .sweep_step_i(sweep_step), .sweep_div_i(sweep_div), .settle_i(settle), .lost_i(lost),
    .max_retry_i(max_retry), .pid_out_i(pid_out), .pid_en_o(pid_en), .dac_o(dac),
    .state_o(state), .locked_o(locked), .fault_o(fault), .retry_o(retry)
  );

  // behavioural model: states 0 idle, 1 sweep, 2 settle, 3 locked, 4 fault
  int m_state = 0, m_ramp = 0, m_dir = 1, m_age = 0, m_hold = 0;
  int m_settle = 0, m_lost = 0, m_retry = 0, m_dac = 8191;
  logic m_pid_en = 1'b0, m_locked = 1'b0, m_fault = 1'b0;

  always @(posedge clk or posedge rst) begin
    int stp, dv, lst, nr;
    bit lose;
    if (rst) begin
      m_state = 0; m_ramp = 0; m_dir = 1; m_age = 0; m_hold = 0;
      m_settle = 0; m_lost = 0; m_retry = 0;
    end else if (!arm) begin
      m_state = 0;
    end else begin
      stp  = (sweep_step == 0) ? 1 : int'(sweep_step);
      dv   = (sweep_div == 0) ? 1 : int'(sweep_div);
      lst  = (lost == 0) ? 1 : int'(lost);
      lose = 1'b0;
      case (m_state)
        0: begin
          m_retry = 0;
          if (int'(sweep_min) >= int'(sweep_max)) m_state = 4;
          else begin m_state = 1; m_ramp = int'(sweep_min); m_dir = 1; m_age = 0; end
        end
        1: begin
          if (int'(trans) >= int'(thr_lock)) begin
            m_hold = m_ramp; m_state = 2; m_settle = 0;
          end else begin
            m_age++;
            if (m_age % dv == 0) begin
              nr = m_ramp + m_dir * stp;
              if (m_dir > 0 && nr >= int'(sweep_max)) begin m_ramp = int'(sweep_max); m_dir = -1; end
              else if (m_dir < 0 && nr <= int'(sweep_min)) begin m_ramp = int'(sweep_min); m_dir = 1; end
              else m_ramp = nr;
            end
          end
        end
        2: begin
          if (int'(trans) < int'(thr_loss)) lose = 1'b1;
          else begin
            m_settle++;
            if (m_settle >= int'(settle)) begin m_state = 3; m_lost = 0; end
          end
        end
        3: begin
          if (int'(trans) < int'(thr_loss)) begin
            m_lost++;
            if (m_lost >= lst) lose = 1'b1;
          end else m_lost = 0;
        end
        default: ;
      endcase
      if (lose) begin
        m_retry = (m_retry < 15) ? m_retry + 1 : 15;
        if (m_retry > int'(max_retry)) m_state = 4;
        else begin m_state = 1; m_ramp = m_hold; m_dir = 1; m_age = 0; end
      end
    end
    m_pid_en = (m_state == 2 || m_state == 3);
    m_locked = (m_state == 3);
    m_fault  = (m_state == 4);
    if (m_state == 1) m_dac = m_ramp;
    else if (m_pid_en) begin
      nr = m_hold + int'(pid_out) - 8191;
      m_dac = (nr < 0) ? 0 : ((nr > 16383) ? 16383 : nr);
    end else m_dac = 8191;
  end

  always @(negedge clk) begin
    checks++;
    if (pid_en !== m_pid_en || dac !== 14'(m_dac) || state !== 3'(m_state) ||
        locked !== m_locked || fault !== m_fault || retry !== 4'(m_retry)) begin
      errors++;
      $display("FAIL model t=%0t: dut en=%0b dac=%0d st=%0d lk=%0b ft=%0b rt=%0d expected en=%0b dac=%0d st=%0d lk=%0b ft=%0b rt=%0d",
               $time, pid_en, dac, state, locked, fault, retry,
               m_pid_en, m_dac, m_state, m_locked, m_fault, m_retry);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int tri_val(input int i);
    int k;
    k = (i / 4) % 20;
    return (k < 10) ? 1000 + 10 * k : 1100 - 10 * (k - 10);
  endfunction

  initial begin
    int n;
    step(2);
    check("rst_dac", dac, 8191);
    check("rst_state", state, 0);
    check("rst_pid_en", pid_en, 0);
    check("rst_retry", retry, 0);

    // triangle sweep
    rst = 1'b0; arm = 1'b1;
    step();
    for (int i = 0; i < 80; i++) begin
      check("tri_dac", dac, tri_val(i));
      step();
    end

    // capture at 1050
    n = 0;
    while (dac != 14'd1050 && n < 200) begin step(); n++; end
    check("reach_1050", dac, 1050);
    trans = 16'sd2000; pid_out = 14'd8191;
    step();
    check("cap_pid_en", pid_en, 1);
    check("cap_dac", dac, 1050);
    check("cap_state", state, 2);
    pid_out = 14'd8291;
    step();
    check("pid_offset_dac", dac, 1150);
    step(98);
    check("settle_99", state, 2);
    step();
    check("locked_state", state, 3);
    check("locked_flag", locked, 1);

    // loss-of-lock dwell
    trans = 16'sd0; step(7);
    check("low7_locked", state, 3);
    trans = 16'sd2000; step();
    trans = 16'sd0; step(7);
    check("low7b_locked", state, 3);
    step();
    check("loss_state", state, 1);
    check("loss_retry", retry, 1);
    check("loss_pid_en", pid_en, 0);
    check("loss_dac", dac, 1050);

    // retry limit
    trans = 16'sd2000; step();
    trans = 16'sd0; step();
    check("retry2", retry, 2);
    trans = 16'sd2000; step();
    trans = 16'sd0; step();
    check("fault_state", state, 4);
    check("fault_flag", fault, 1);
    check("fault_dac", dac, 8191);
    check("fault_retry", retry, 3);
    trans = 16'sd2000; step(3);
    check("fault_sticky", state, 4);
    arm = 1'b0; step();
    check("disarm_idle", state, 0);
    arm = 1'b1; step();
    check("rearm_sweep", state, 1);
    check("rearm_retry", retry, 0);

    // saturation
    arm = 1'b0; sweep_min = 14'd16300; sweep_max = 14'd16383; trans = 16'sd2000; step();
    arm = 1'b1; step();
    check("sat_hi_sweep", dac, 16300);
    pid_out = 14'd16383; step();
    check("sat_hi_dac", dac, 16383);
    arm = 1'b0; sweep_min = 14'd50; sweep_max = 14'd100; step();
    arm = 1'b1; step();
    pid_out = 14'd0; step();
    check("sat_lo_dac", dac, 0);
    check("sat_lo_state", state, 2);

    // zero step and divider act as one
    arm = 1'b0; sweep_min = 14'd1000; sweep_max = 14'd1100; sweep_step = 8'd0;
    sweep_div = '0; trans = 16'sd0; pid_out = 14'd8191; step();
    arm = 1'b1; step();
    check("zero_cfg_0", dac, 1000);
    step();
    check("zero_cfg_1", dac, 1001);
    step(2);
    check("zero_cfg_3", dac, 1003);

    // async reset while locked, then degenerate sweep window
    arm = 1'b0; sweep_step = 8'd10; sweep_div = 14'd4; settle = 16'd2; step();
    arm = 1'b1; step();
    trans = 16'sd2000; step();
    step(2);
    check("pre_rst_locked", state, 3);
    #2 rst = 1'b1;
    #1;
    check("async_rst_state", state, 0);
    check("async_rst_dac", dac, 8191);
    check("async_rst_pid_en", pid_en, 0);
    check("async_rst_locked", locked, 0);
    arm = 1'b0; sweep_max = 14'd1000; step();
    rst = 1'b0; arm = 1'b1; step();
    check("eq_window_fault", state, 4);
    check("eq_window_flag", fault, 1);
    check("eq_window_dac", dac, 8191);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
